// File: rtl/matrix_write_loader.sv
// matrix_write_loader: streams row_count rows into layer storage, one write per accepted row; optional checksum under LOADER_CHECKSUM_EN
module matrix_write_loader (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic [31:0] layer_index,
  input  logic [31:0] row_count,
  input  logic        abort,
  input  logic [47:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] write_layer_index,
  output logic [31:0] write_row_index,
  output logic [47:0] write_data,
  output logic        is_write,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
  state_t      state_q, state_d;
  logic [31:0] layer_q, layer_d, rows_q, rows_d, cnt_q, cnt_d;
  logic [31:0] wr_layer_q, wr_layer_d, wr_row_q, wr_row_d;
  logic [47:0] wr_data_q, wr_data_d;
  logic        is_write_q, is_write_d, done_q, done_d;
  logic        accept;
  assign in_ready          = (state_q == LOAD) && (cnt_q < rows_q);
  assign accept            = in_ready && in_valid && !abort;
  assign busy              = state_q != IDLE;
  assign is_write          = is_write_q;
  assign done              = done_q;
  assign write_layer_index = wr_layer_q;
  assign write_row_index   = wr_row_q;
  assign write_data        = wr_data_q;
  // next-state, parameter latching and registered write port
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    rows_d     = rows_q;
    cnt_d      = cnt_q;
    wr_layer_d = wr_layer_q;
    wr_row_d   = wr_row_q;
    wr_data_d  = wr_data_q;
    is_write_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (row_count == 32'd0) done_d = 1'b1;
        else begin
          layer_d = layer_index;
          rows_d  = row_count;
          cnt_d   = 32'd0;
          state_d = LOAD;
        end
      end
      LOAD: if (abort) state_d = IDLE;
      else if (accept) begin
        wr_layer_d = layer_q;
        wr_row_d   = cnt_q;
        wr_data_d  = in_data;
        is_write_d = 1'b1;
        cnt_d      = cnt_q + 32'd1;
        if (cnt_q == rows_q - 32'd1) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      rows_q     <= '0;
      cnt_q      <= '0;
      wr_layer_q <= '0;
      wr_row_q   <= '0;
      wr_data_q  <= '0;
      is_write_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      rows_q     <= rows_d;
      cnt_q      <= cnt_d;
      wr_layer_q <= wr_layer_d;
      wr_row_q   <= wr_row_d;
      wr_data_q  <= wr_data_d;
      is_write_q <= is_write_d;
      done_q     <= done_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;
  assign checksum = cs_q;
  // running lane sum, cleared on a start taken in IDLE, visible with each write
  always_comb begin
    cs_d = (state_q == IDLE && start) ? 16'd0 :
           accept ? cs_q + in_data[15:0] + in_data[31:16] + in_data[47:32] : cs_q;
  end
  // checksum register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) cs_q <= '0;
    else cs_q <= cs_d;
  end
`endif
endmodule

// File: tb/tb_matrix_write_loader.sv
// tb_matrix_write_loader: directed self-checking bench for matrix_write_loader
module tb_matrix_write_loader;
  logic        clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [31:0] layer_index = '0, row_count = '0;
  logic [47:0] in_data = '0;
  logic        in_ready, is_write, busy, done;
  logic [31:0] write_layer_index, write_row_index;
  logic [47:0] write_data;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [47:0] wd[$];
  int wr[$], wl[$], wc[$];

  matrix_write_loader dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .layer_index(layer_index), .row_count(row_count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .write_layer_index(write_layer_index), .write_row_index(write_row_index),
    .write_data(write_data), .is_write(is_write), .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc++;
  always @(negedge clk_clk) begin
    if (is_write) begin
      wd.push_back(write_data);
      wr.push_back(int'(write_row_index));
      wl.push_back(int'(write_layer_index));
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk_clk);
  endtask

  task automatic clr();
    wd.delete(); wr.delete(); wl.delete(); wc.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({in_ready, is_write, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {in_ready, is_write, busy, done}); end
    checks++; if ({write_layer_index, write_row_index, write_data} !== 112'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", {write_layer_index, write_row_index, write_data}); end
    step(); step();
    reset_reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [47:0] d[3];
    d[0] = 48'hAAAA_0001_1111; d[1] = 48'hBBBB_0002_2222; d[2] = 48'hCCCC_0003_3333;
    clr();
    start = 1'b1; layer_index = 32'd2; row_count = 32'd3;
    step();
    start = 1'b0;
    checks++; if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL basic_load got %b exp 11", {busy, in_ready}); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = d[i];
      step();
    end
    in_valid = 1'b0;
    checks++; if ({busy, in_ready, is_write} !== 3'b101) begin errors++; $display("FAIL basic_finish got %b exp 101", {busy, in_ready, is_write}); end
    step(); step(); step();
    checks++; if (wd.size() !== 3) begin errors++; $display("FAIL basic_count got %0d exp 3", wd.size()); end
    for (int i = 0; i < 3 && i < wd.size(); i++) begin
      checks++; if (wd[i] !== d[i] || wr[i] !== i || wl[i] !== 2) begin errors++; $display("FAIL basic_row%0d got %h/%0d/%0d exp %h/%0d/2", i, wd[i], wr[i], wl[i], d[i], i); end
      checks++; if (wc[i] !== wc[0] + i) begin errors++; $display("FAIL basic_consec%0d got %0d exp %0d", i, wc[i], wc[0] + i); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    if (wc.size() == 3) begin
      checks++; if (done_cyc !== wc[2] + 1) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, wc[2] + 1); end
    end
  endtask

  task automatic test_gaps();
    clr();
    start = 1'b1; layer_index = 32'd7; row_count = 32'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2) == 0;
      in_data = in_valid ? 48'h0000_1000_0000 + 48'(i / 2) : 48'hDEAD_BEEF_0BAD;
      start = (i == 3); layer_index = 32'd99; row_count = 32'd0;
      step();
    end
    in_valid = 1'b0; start = 1'b0;
    step(); step(); step();
    checks++; if (wd.size() !== 4) begin errors++; $display("FAIL gaps_count got %0d exp 4", wd.size()); end
    for (int i = 0; i < 4 && i < wd.size(); i++) begin
      checks++; if (wd[i] !== 48'h0000_1000_0000 + 48'(i) || wr[i] !== i || wl[i] !== 7) begin errors++; $display("FAIL gaps_row%0d got %h/%0d/%0d exp %h/%0d/7", i, wd[i], wr[i], wl[i], 48'h0000_1000_0000 + 48'(i), i); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gaps_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (write_row_index !== 32'd3 || write_data !== 48'h0000_1000_0003) begin errors++; $display("FAIL gaps_hold got %0d/%h exp 3/000010000003", write_row_index, write_data); end
  endtask

  task automatic test_zero();
    clr();
    start = 1'b1; row_count = 32'd0; layer_index = 32'd5;
    step();
    start = 1'b0;
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done got %b exp 10", {done, busy}); end
    step();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_after got %b exp 00", {done, busy}); end
    step();
    checks++; if (wd.size() !== 0 || done_cnt !== 1) begin errors++; $display("FAIL zero_writes got %0d/%0d exp 0/1", wd.size(), done_cnt); end
  endtask

  task automatic test_abort();
    clr();
    start = 1'b1; layer_index = 32'd4; row_count = 32'd5;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 48'h1;
    step();
    in_data = 48'h2; abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    checks++; if ({busy, is_write} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b exp 00", {busy, is_write}); end
    in_valid = 1'b1; in_data = 48'h3;
    step(); step();
    in_valid = 1'b0;
    step();
    checks++; if (wd.size() !== 1 || done_cnt !== 0) begin errors++; $display("FAIL abort_writes got %0d/%0d exp 1/0", wd.size(), done_cnt); end
  endtask

  task automatic test_reset_mid();
    clr();
    start = 1'b1; layer_index = 32'd3; row_count = 32'd3;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 48'h5555;
    step();
    in_valid = 1'b0;
    checks++; if (is_write !== 1'b1) begin errors++; $display("FAIL mid_prewrite got %b exp 1", is_write); end
    #2 reset_reset_n = 1'b0;
    #1;
    checks++; if ({in_ready, is_write, busy, done} !== 4'b0) begin errors++; $display("FAIL mid_flags got %b exp 0000", {in_ready, is_write, busy, done}); end
    checks++; if ({write_layer_index, write_row_index, write_data} !== 112'd0) begin errors++; $display("FAIL mid_bus got %h exp 0", {write_layer_index, write_row_index, write_data}); end
    step();
    reset_reset_n = 1'b1;
    step();
    clr();
    start = 1'b1; layer_index = 32'd9; row_count = 32'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 48'h0123_4567_89AB;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++; if (wd.size() !== 1 || done_cnt !== 1) begin errors++; $display("FAIL mid_new got %0d/%0d exp 1/1", wd.size(), done_cnt); end
    if (wd.size() == 1) begin
      checks++; if (wd[0] !== 48'h0123_4567_89AB || wr[0] !== 0 || wl[0] !== 9) begin errors++; $display("FAIL mid_row got %h/%0d/%0d exp 0123456789ab/0/9", wd[0], wr[0], wl[0]); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [47:0] d[2];
    logic [15:0] cs_at_done = 16'hxxxx;
    d[0] = 48'h0003_0002_0001; d[1] = 48'h0001_0000_FFFF;
    clr();
    start = 1'b1; layer_index = 32'd1; row_count = 32'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = d[i];
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) cs_at_done = checksum;
      step();
    end
    checks++; if (cs_at_done !== 16'h0006) begin errors++; $display("FAIL checksum got %h exp 0006", cs_at_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_abort();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
